// File: rtl/seq_gen.sv
// Serial frame generator: 6-bit sync word, DATA_W payload bits MSB first, then
// one even-parity bit, followed by a one-cycle done pulse.
module seq_gen #(
    parameter int         DATA_W = 8,
    parameter logic [5:0] SYNC   = 6'b101110
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W = 6 + DATA_W;
    localparam int MAX_LEN = (DATA_W > 6) ? DATA_W : 6;
    localparam int CNT_W   = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_PAR
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] frame_q;
    logic               par_q;
    logic               out_q;
    logic               busy_q;
    logic               done_q;

    // frame_q holds the bits still to be sent after the one currently on out;
    // cnt_q counts down the bits left in the current state (0 = last one).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        frame_q <= {SYNC[4:0], data, 1'b0};
                        par_q   <= ^data;
                        cnt_q   <= CNT_W'(5);
                        out_q   <= SYNC[5];
                        busy_q  <= 1'b1;
                        state_q <= S_SYNC;
                    end else begin
                        out_q  <= 1'b0;
                        busy_q <= 1'b0;
                    end
                end
                S_SYNC: begin
                    out_q   <= frame_q[FRAME_W-1];
                    frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
                    if (cnt_q == '0) begin
                        cnt_q   <= CNT_W'(DATA_W - 1);
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        out_q   <= par_q;
                        state_q <= S_PAR;
                    end else begin
                        out_q   <= frame_q[FRAME_W-1];
                        frame_q <= {frame_q[FRAME_W-2:0], 1'b0};
                        cnt_q   <= cnt_q - 1'b1;
                    end
                end
                S_PAR: begin
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen: table of single frames plus hand-written
// sequences for back-to-back, ignored-start, reset-priority and abort cases.
module tb_seq_gen;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data;
    logic       out;
    logic       busy;
    logic       done;

    int checks       = 0;
    int failures     = 0;
    int framesSent   = 0;
    int matchCount   = 0;
    logic [4:0] detHist = 5'b0;

    typedef struct {
        logic [7:0]  dataVal;
        logic [14:0] frameBits;
        bit          interfere;
    } vec_t;

    vec_t vectors[6];
    logic [14:0] frameFF;
    logic [14:0] frameA5;

    seq_gen #(.DATA_W(8), .SYNC(6'b101110)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .data  (data),
        .out   (out),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Independent sync-word detector watching the serial line.
    always @(negedge clk) begin
        if ({detHist, out} == 6'b101110) matchCount++;
        detHist <= {detHist[3:0], out};
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] dataVal, input logic [14:0] frameBits, input bit interfere);
        @(negedge clk);
        start = 1'b1;
        data  = dataVal;
        @(negedge clk);
        start = 1'b0;
        data  = ~dataVal;
        framesSent++;
        for (int i = 0; i < 15; i++) begin
            checkOutput($sformatf("bit%0d_data%0h", i, dataVal), {15'b0, out}, {15'b0, frameBits[14-i]});
            checkOutput($sformatf("busy%0d", i), {15'b0, busy}, 16'd1);
            checkOutput($sformatf("doneLow%0d", i), {15'b0, done}, 16'd0);
            if (interfere && (i == 3 || i == 8)) begin
                start = 1'b1;
                data  = 8'h3C;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("doneHigh", {15'b0, done}, 16'd1);
        checkOutput("doneBusy", {15'b0, busy}, 16'd0);
        checkOutput("doneOut", {15'b0, out}, 16'd0);
        @(negedge clk);
        checkOutput("doneOnce", {15'b0, done}, 16'd0);
        checkOutput("idleBusy", {15'b0, busy}, 16'd0);
        checkOutput("idleOut", {15'b0, out}, 16'd0);
    endtask

    initial begin
        vectors[0] = '{8'hA5, 15'b101110_10100101_0, 1'b0};
        vectors[1] = '{8'h07, 15'b101110_00000111_1, 1'b0};
        vectors[2] = '{8'h00, 15'b101110_00000000_0, 1'b0};
        vectors[3] = '{8'h81, 15'b101110_10000001_0, 1'b0};
        vectors[4] = '{8'h01, 15'b101110_00000001_1, 1'b0};
        vectors[5] = '{8'hA5, 15'b101110_10100101_0, 1'b1};
        frameFF = 15'b101110_11111111_0;
        frameA5 = 15'b101110_10100101_0;

        rst   = 1'b1;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("resetOut", {15'b0, out}, 16'd0);
        checkOutput("resetBusy", {15'b0, busy}, 16'd0);
        checkOutput("resetDone", {15'b0, done}, 16'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++)
            applyStimulus(vectors[v].dataVal, vectors[v].frameBits, vectors[v].interfere);

        // Continuous start: frames every 16 cycles, accepted in the done cycle.
        @(negedge clk);
        start = 1'b1;
        data  = 8'hFF;
        for (int k = 0; k < 49; k++) begin
            @(negedge clk);
            if (k % 16 == 0 && k < 48) framesSent++;
            if (k == 48) begin
                checkOutput("b2bIdleBusy", {15'b0, busy}, 16'd0);
                checkOutput("b2bIdleDone", {15'b0, done}, 16'd0);
                checkOutput("b2bIdleOut", {15'b0, out}, 16'd0);
            end else if (k % 16 == 15) begin
                checkOutput($sformatf("b2bDone%0d", k), {15'b0, done}, 16'd1);
                checkOutput($sformatf("b2bDoneOut%0d", k), {15'b0, out}, 16'd0);
                checkOutput($sformatf("b2bDoneBusy%0d", k), {15'b0, busy}, 16'd0);
            end else begin
                checkOutput($sformatf("b2bBit%0d", k), {15'b0, out}, {15'b0, frameFF[14-(k%16)]});
                checkOutput($sformatf("b2bBusy%0d", k), {15'b0, busy}, 16'd1);
            end
            start = (k < 39);
        end
        start = 1'b0;

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        data  = 8'h5A;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("rstPrioBusy", {15'b0, busy}, 16'd0);
        checkOutput("rstPrioOut", {15'b0, out}, 16'd0);
        @(negedge clk);
        checkOutput("rstPrioBusy2", {15'b0, busy}, 16'd0);
        checkOutput("rstPrioDone2", {15'b0, done}, 16'd0);

        // Abort at frame bit 9, then a clean frame afterwards.
        @(negedge clk);
        start = 1'b1;
        data  = 8'hA5;
        @(negedge clk);
        start = 1'b0;
        framesSent++;
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("abortBit%0d", i), {15'b0, out}, {15'b0, frameA5[14-i]});
            if (i < 9) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abortOut", {15'b0, out}, 16'd0);
        checkOutput("abortBusy", {15'b0, busy}, 16'd0);
        checkOutput("abortDone", {15'b0, done}, 16'd0);
        @(negedge clk);
        checkOutput("abortNoDone", {15'b0, done}, 16'd0);
        checkOutput("abortOut2", {15'b0, out}, 16'd0);
        applyStimulus(8'hA5, frameA5, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("syncMatches", 16'(matchCount), 16'(framesSent));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal range 1-16).
REQ-002 Parameter SYNC, default 6'b101110, sync pattern, transmitted MSB first.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high, sampled on posedge clk.
REQ-005 start  input  1  frame request, sampled on posedge clk.
REQ-006 data  input  DATA_W  payload, captured on the cycle start is accepted.
REQ-007 out  output  1  registered serial bit stream.
REQ-008 busy  output  1  registered; high while a frame is being shifted out.
REQ-009 done  output  1  registered; one-cycle pulse after the last frame bit.

Function
REQ-010 Frame format SHALL be 6 sync bits, then DATA_W payload bits, then 1 even-parity bit; total 7+DATA_W bits.
REQ-011 Sync bits SHALL be SYNC[5] down to SYNC[0]; payload bits SHALL be data[DATA_W-1] down to data[0].
REQ-012 Parity bit SHALL equal XOR of all captured payload bits (even parity over the payload).
REQ-013 FSM states SHALL be IDLE, SYNC, DATA, PAR.
REQ-014 IDLE: start=1 at posedge SHALL capture data into a shift register, load the bit counter, and go to SYNC; otherwise stay in IDLE.
REQ-015 SYNC SHALL last exactly 6 cycles, then go to DATA.
REQ-016 DATA SHALL last exactly DATA_W cycles, then go to PAR.
REQ-017 PAR SHALL last exactly 1 cycle, then go to IDLE.
REQ-018 Latency: if start is accepted at edge N, the first sync bit SHALL appear on out after edge N, and the parity bit after edge N+6+DATA_W.
REQ-019 out SHALL be 0 whenever the FSM is in IDLE.
REQ-020 busy SHALL be 1 exactly during the 7+DATA_W cycles in which frame bits are on out.
REQ-021 done SHALL be 1 for exactly one cycle, the cycle immediately after the parity bit, with busy=0 and out=0.
REQ-022 start while busy=1 SHALL be ignored; no queuing.
REQ-023 Changes to data after acceptance SHALL NOT affect the frame in flight.
REQ-024 start=1 during the done cycle SHALL be accepted, because the FSM is in IDLE. The next frame's first bit SHALL follow directly, giving exactly one idle 0 between frames.
REQ-025 start held high continuously SHALL produce back-to-back frames, each separated by one done/idle cycle.
REQ-026 The bit counter SHALL be wide enough for max(6, DATA_W) and SHALL NOT wrap within a state.

Reset
REQ-027 On rst=1 at posedge, the FSM SHALL go to IDLE and out, busy and done SHALL be 0 after that edge.
REQ-028 rst SHALL take priority over start in the same cycle; the frame is not accepted.
REQ-029 rst mid-frame SHALL abort the frame immediately, with no done pulse and no residual bits.
REQ-030 Shift register and counter contents after reset are don't-care; outputs SHALL NOT depend on them in IDLE.

Verification
REQ-031 Reset, then start=1 with data=8'hA5 for one cycle -> out = 1,0,1,1,1,0, 1,0,1,0,0,1,0,1, 0 over 15 cycles; busy high for those 15 cycles; done high on cycle 16.
REQ-032 data=8'h07 -> parity bit=1; data=8'h00 -> out = 101110 00000000 0.
REQ-033 start held high for 40 cycles with data=8'hFF -> frames repeat with a 16-cycle period; each done cycle shows out=0; every frame's parity bit=0.
REQ-034 start pulsed at cycles 3 and 8 after acceptance, with data changed to 8'h3C -> second request ignored; frame still carries 8'hA5; only one done pulse.
REQ-035 rst asserted at frame bit 9 -> out, busy, done = 0 from the next cycle; no done pulse; a new start 2 cycles later yields a complete, correct frame.
REQ-036 Checker: a serial 101110 detector on out raises a match for every transmitted frame, and the bench compares the total match count against the number of frames sent.
